// File: rtl/cell_pool.sv
// Fixed-size cell allocator: LIFO free stack plus bump pointer over a 2^ADDR_SZ x 16 store.
// Optional macro CELL_POOL_CHECK_EN adds a per-cell allocated bitmap for use-after-free checks.
module cell_pool #(
   parameter int unsigned ADDR_SZ = 8
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_alloc,
   input  logic [15:0]        i_data,
   output logic [15:0]        o_addr,
   input  logic               i_free,
   input  logic [15:0]        i_addr,
   input  logic               i_wr,
   input  logic [15:0]        i_waddr,
   input  logic [15:0]        i_wdata,
   input  logic               i_rd,
   input  logic [15:0]        i_raddr,
   output logic [15:0]        o_rdata,
   output logic [ADDR_SZ:0]   o_avail,
   output logic               o_err
);
   localparam int unsigned N_CELLS = 1 << ADDR_SZ;
   localparam int unsigned CW      = ADDR_SZ + 1;
   localparam logic [15:0] NIL     = 16'h0001;

   logic [15:0]        r_mem   [N_CELLS];
   logic [ADDR_SZ-1:0] r_stack [N_CELLS];
   logic [CW-1:0]      r_sp, r_bump, r_avail;
   logic [15:0]        r_addr, r_rdata;
   logic               r_err;

   logic [ADDR_SZ-1:0] w_fidx, w_widx, w_ridx, w_top, w_alloc_idx, w_sp_dec;
   logic               w_stack_empty, w_full, w_empty, w_bad_use, w_err, w_go;

   function automatic logic in_range(input logic [15:0] p);
      return p[15] && ((p[14:0] >> ADDR_SZ) == 15'd0);
   endfunction

   assign w_fidx        = i_addr[ADDR_SZ-1:0];
   assign w_widx        = i_waddr[ADDR_SZ-1:0];
   assign w_ridx        = i_raddr[ADDR_SZ-1:0];
   assign w_sp_dec      = ADDR_SZ'(r_sp - CW'(1));
   assign w_top         = r_stack[w_sp_dec];
   assign w_stack_empty = (r_sp == '0);
   assign w_full        = (r_avail == CW'(N_CELLS));
   assign w_empty       = (r_avail == '0);
   assign w_alloc_idx   = w_stack_empty ? r_bump[ADDR_SZ-1:0] : w_top;

`ifdef CELL_POOL_CHECK_EN
   logic [N_CELLS-1:0] r_used;

   // Touching an in-range cell that is not currently allocated is an error.
   assign w_bad_use = (i_free && in_range(i_addr)  && !r_used[w_fidx]) ||
                      (i_rd   && in_range(i_raddr) && !r_used[w_ridx]) ||
                      (i_wr   && in_range(i_waddr) && !r_used[w_widx]);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_used <= '0;
      end else if (w_go) begin
         if (i_alloc && !i_free) r_used[w_alloc_idx] <= 1'b1;
         else if (i_free && !i_alloc) r_used[w_fidx] <= 1'b0;
      end
   end
`else
   assign w_bad_use = 1'b0;
`endif

   always_comb begin
      w_err = 1'b0;
      if (i_alloc && !i_free && w_empty)                        w_err = 1'b1;
      if (i_free && (!in_range(i_addr) || w_full))              w_err = 1'b1;
      if (i_rd && !in_range(i_raddr))                           w_err = 1'b1;
      if (i_wr && (!in_range(i_waddr) || i_alloc || i_free))    w_err = 1'b1;
      if (w_bad_use)                                            w_err = 1'b1;
   end

   assign w_go = !r_err && !w_err;

   // Control state; an erroring cycle commits nothing except the sticky flag.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_sp    <= '0;
         r_bump  <= '0;
         r_avail <= CW'(N_CELLS);
         r_addr  <= NIL;
         r_rdata <= NIL;
         r_err   <= 1'b0;
      end else if (!r_err) begin
         if (w_err) begin
            r_err <= 1'b1;
         end else begin
            if (i_alloc && i_free) begin
               r_addr <= 16'h8000 | 16'(w_fidx);
            end else if (i_alloc) begin
               r_addr  <= 16'h8000 | 16'(w_alloc_idx);
               r_avail <= r_avail - CW'(1);
               if (!w_stack_empty)                r_sp   <= r_sp - CW'(1);
               else if (r_bump != CW'(N_CELLS))   r_bump <= r_bump + CW'(1);
            end else if (i_free) begin
               r_sp    <= r_sp + CW'(1);
               r_avail <= r_avail + CW'(1);
            end
            if (i_rd) r_rdata <= r_mem[w_ridx];
         end
      end
   end

   // Storage and free stack: no reset, gated by the same commit condition.
   always_ff @(posedge i_clk) begin
      if (!i_rst && w_go) begin
         if (i_alloc)   r_mem[i_free ? w_fidx : w_alloc_idx] <= i_data;
         else if (i_wr) r_mem[w_widx] <= i_wdata;
         if (i_free && !i_alloc) r_stack[r_sp[ADDR_SZ-1:0]] <= w_fidx;
      end
   end

   assign o_addr  = r_addr;
   assign o_rdata = r_rdata;
   assign o_avail = r_avail;
   assign o_err   = r_err;
endmodule

// File: doc/cell_pool.md
CELL_POOL -- requirements
Module: cell_pool

Interface
REQ-001 Parameter ADDR_SZ, default 8, log2 of cell count; legal range 3..14.
REQ-002 i_clk  in  1  system clock; all state changes on rising edge.
REQ-003 i_rst  in  1  reset, synchronous, active-high.
REQ-004 i_alloc  in  1  allocate one cell, initialised to i_data.
REQ-005 i_data  in  16  initial contents of the allocated cell.
REQ-006 o_addr  out  16  pointer to the most recently allocated cell.
REQ-007 i_free  in  1  release the cell named by i_addr.
REQ-008 i_addr  in  16  pointer to the cell being freed.
REQ-009 i_wr / i_waddr / i_wdata  in  1/16/16  write i_wdata to cell i_waddr.
REQ-010 i_rd / i_raddr  in  1/16  read cell i_raddr.
REQ-011 o_rdata  out  16  data from the most recent read.
REQ-012 o_avail  out  ADDR_SZ+1  number of cells currently free.
REQ-013 o_err  out  1  sticky error flag.

Function
REQ-014 A cell pointer SHALL be 16'h8000 | index, index in 0..2^ADDR_SZ-1; NIL is 16'h0001 and is never a cell pointer.
REQ-015 A pointer SHALL be in range iff bit 15 is set and bits [14:ADDR_SZ] are zero.
REQ-016 Cell storage SHALL be 2^ADDR_SZ x 16 bits with one write port and one synchronous read port.
REQ-017 Alloc source priority SHALL be: the top of the free stack if it is non-empty, otherwise the bump pointer (next never-used index).
REQ-018 Alloc in cycle N SHALL write i_data to the chosen cell at edge N; o_addr SHALL be valid from N+1 and hold until the next alloc.
REQ-019 Free in cycle N SHALL push the index onto the free stack; the free stack SHALL be LIFO with 2^ADDR_SZ entries and asynchronous read.
REQ-020 Simultaneous alloc and free SHALL return the freed cell as o_addr, write i_data into it, and leave the stack and o_avail unchanged.
REQ-021 Read in cycle N SHALL present data at o_rdata from N+1 and hold it until the next read; a read and a write to the same cell in one cycle SHALL return the old data.
REQ-022 A read concurrent with alloc, free or write SHALL be legal.
REQ-023 o_avail SHALL decrement on alloc, increment on free, and be unchanged on alloc+free or on an erroring cycle.
REQ-024 o_err SHALL be set at the edge after any of: alloc while o_avail==0 (without concurrent free); free, read or write of an out-of-range pointer; i_wr together with i_alloc or i_free.
REQ-025 Free while o_avail==2^ADDR_SZ SHALL set o_err.
REQ-026 Once o_err is set, every request SHALL be ignored and all state SHALL be frozen until reset.
REQ-027 The bump pointer SHALL saturate at 2^ADDR_SZ and never wrap.

Reset
REQ-028 i_rst SHALL take priority over every request in the same cycle, including mid-operation.
REQ-029 After reset: o_addr=NIL, o_rdata=NIL, o_err=0, o_avail=2^ADDR_SZ, bump pointer=0, free stack empty; cell contents are undefined.

Configuration
REQ-030 With macro CELL_POOL_CHECK_EN defined, the block SHALL keep one allocated bit per cell, set on alloc and cleared on free.
REQ-031 With CELL_POOL_CHECK_EN defined, free, read or write of an in-range cell whose allocated bit is clear SHALL set o_err.
REQ-032 Without CELL_POOL_CHECK_EN, the allocated bitmap SHALL be absent and only the range and occupancy checks of REQ-024/025 SHALL apply.

Verification
REQ-033 ADDR_SZ=4: reset, then 16 consecutive allocs with i_data=NIL -> o_addr=8000..800F in order, o_avail=0, o_err=0; a 17th alloc -> o_err=1 one cycle later.
REQ-034 Build a 16-cell list (each alloc's i_data = previous o_addr), then follow it by reads from the last o_addr -> 15 hops visit 800E..8000, the final o_rdata=0001, o_err=0.
REQ-035 Alloc 3 cells, free 8001 then 8002, alloc twice -> o_addr=8002 then 8001; a third alloc -> 8003; o_avail tracks 13,14,15,14,13,12.
REQ-036 Alloc+free of 8000 in the same cycle -> o_addr=8000 next cycle, o_avail unchanged; i_wr with i_alloc -> o_err=1.
REQ-037 Read of 4000 or 8010 (ADDR_SZ=4) -> o_err=1; read of a never-allocated 8005 -> o_err=1 with CELL_POOL_CHECK_EN, o_err=0 without.
REQ-038 Assert i_rst concurrently with alloc after 5 allocs -> next cycle o_addr=NIL, o_avail=16, o_err=0; the next alloc returns 8000.
